// File: rtl/mem_responder_if.sv
// Processor-side memory bus: address, write data and write strobe from the CPU,
// registered read data back to it.
interface mem_responder_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;

  modport master (output ADDR, output DOUT, output W, input DIN);
  modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: boot-loads a program image into local RAM, then serves
// processor word reads/writes plus an LED register and a synchronised switch port.
module mem_responder #(
  parameter int         AW      = 7,
  parameter logic [3:0] LED_SEL = 4'h1,
  parameter logic [3:0] SW_SEL  = 4'h3
) (
  input  logic              clock,
  input  logic              resetN,
  mem_responder_if.slave    bus,
  output logic              run,
  input  logic              ld_valid,
  input  logic [15:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [15:0]       sw,
  output logic [15:0]       ledOut
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [0:0] {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_ptr;
  logic            r_run;
  logic            r_ld_ready;
  logic [15:0]     r_din;
  logic [15:0]     r_led;
  logic [15:0]     r_sw_meta;
  logic [15:0]     r_sw_sync;
  logic [15:0]     r_mem [DEPTH];

  logic [3:0]      w_sel;
  logic            w_is_led;
  logic            w_is_sw;
  logic            w_ptr_max;
  logic            w_accept;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic [15:0]     w_mem_wdata;
  logic [15:0]     w_din_nxt;
  logic            w_addr_unused;

  assign w_sel         = bus.ADDR[15:12];
  assign w_is_led      = (w_sel == LED_SEL);
  assign w_is_sw       = (w_sel == SW_SEL);
  assign w_ptr_max     = (r_ptr == {AW{1'b1}});
  assign w_accept      = (r_state == S_LOAD) && ld_valid && r_ld_ready;
  // ADDR[11:AW] is deliberately ignored so RAM aliases across that range
  assign w_addr_unused = ^bus.ADDR[11:AW];

  // Next-state: the loader exits on the tagged last word or when RAM is full
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_accept && (ld_last || w_ptr_max)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // RAM port steering and read-data select; a same-address write is seen first
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_ptr;
    w_mem_wdata = ld_data;
    w_din_nxt   = 16'h0000;
    case (r_state)
      S_LOAD: begin
        w_mem_we = w_accept;
      end
      S_RUN: begin
        w_mem_addr  = bus.ADDR[AW-1:0];
        w_mem_wdata = bus.DOUT;
        if (w_is_led) begin
          w_din_nxt = bus.W ? bus.DOUT : r_led;
        end else if (w_is_sw) begin
          w_din_nxt = r_sw_sync;
        end else begin
          w_mem_we  = bus.W;
          w_din_nxt = bus.W ? bus.DOUT : r_mem[bus.ADDR[AW-1:0]];
        end
      end
      default: begin
        w_mem_we  = 1'b0;
        w_din_nxt = 16'h0000;
      end
    endcase
  end

  // Control, pointer, read data, LED and switch synchroniser registers
  always_ff @(posedge clock or posedge resetN) begin
    if (resetN) begin
      r_state    <= S_LOAD;
      r_ptr      <= {AW{1'b0}};
      r_run      <= 1'b0;
      r_ld_ready <= 1'b0;
      r_din      <= 16'h0000;
      r_led      <= 16'h0000;
      r_sw_meta  <= 16'h0000;
      r_sw_sync  <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_ready <= (w_state_nxt == S_LOAD);
      r_run      <= (w_state_nxt == S_RUN);
      if (w_accept && !w_ptr_max) begin
        r_ptr <= r_ptr + AW'(1);
      end
      r_din <= w_din_nxt;
      if ((r_state == S_RUN) && w_is_led && bus.W) begin
        r_led <= bus.DOUT;
      end
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // RAM contents survive reset, so the array has no reset branch
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign bus.DIN  = r_din;
  assign run      = r_run;
  assign ld_ready = r_ld_ready;
  assign ledOut   = r_led;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: boot loading, RUN-mode decode, aliasing,
// LED/switch I/O and reset behaviour, checked with immediate assertions.
module tb_mem_responder;

  logic        clock;
  logic        resetN;
  logic        run;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [15:0] sw;
  logic [15:0] ledOut;
  logic [15:0] rd;
  int          n_checks;
  int          n_fail;

  mem_responder_if bus ();

  mem_responder dut (
    .clock    (clock),
    .resetN   (resetN),
    .bus      (bus),
    .run      (run),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .sw       (sw),
    .ledOut   (ledOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    bus.ADDR = a;
    bus.W    = 1'b0;
    tick();
    d = bus.DIN;
  endtask

  task automatic do_reset();
    resetN = 1'b1;
    tick();
    tick();
    resetN = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetN   = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 16'h0000;
    ld_last  = 1'b0;
    sw       = 16'h0000;
    bus.ADDR = 16'h0000;
    bus.DOUT = 16'h0000;
    bus.W    = 1'b0;

    // Reset state
    #2 resetN = 1'b1;
    #1;
    check("rst_din",    bus.DIN, 16'h0000);
    check("rst_run",    {15'd0, run}, 16'h0000);
    check("rst_ready",  {15'd0, ld_ready}, 16'h0000);
    check("rst_led",    ledOut, 16'h0000);
    tick();
    tick();
    resetN = 1'b0;
    tick();
    check("ready_after_rst", {15'd0, ld_ready}, 16'h0001);

    // 1: three-word boot image with ld_last on the third
    load_word(16'h0107, 1'b0);
    load_word(16'h0005, 1'b0);
    load_word(16'h1234, 1'b1);
    tick();
    check("t1_ready_low", {15'd0, ld_ready}, 16'h0000);
    check("t1_run_high",  {15'd0, run}, 16'h0001);
    bus_read(16'h0000, rd); check("t1_ram0", rd, 16'h0107);
    bus_read(16'h0001, rd); check("t1_ram1", rd, 16'h0005);
    bus_read(16'h0002, rd); check("t1_ram2", rd, 16'h1234);

    // 3: write-first, read-back and aliasing
    bus.ADDR = 16'h0010; bus.DOUT = 16'hBEEF; bus.W = 1'b1;
    tick();
    check("t3_wr_first", bus.DIN, 16'hBEEF);
    bus.W = 1'b0;
    tick();
    check("t3_readback", bus.DIN, 16'hBEEF);
    bus_read(16'h0810, rd); check("t3_alias", rd, 16'hBEEF);

    // 4: LED register and switch synchroniser
    bus.ADDR = 16'h1000; bus.DOUT = 16'h00FF; bus.W = 1'b1;
    tick();
    check("t4_led",       ledOut, 16'h00FF);
    check("t4_led_wr_fst", bus.DIN, 16'h00FF);
    bus_read(16'h1000, rd); check("t4_led_read", rd, 16'h00FF);
    sw = 16'hA5A5;
    bus.ADDR = 16'h3000;
    tick();
    tick();
    tick();
    check("t4_sw_read", bus.DIN, 16'hA5A5);
    bus.DOUT = 16'h1111; bus.W = 1'b1;
    tick();
    bus.W = 1'b0;
    check("t4_sw_wr_ign", bus.DIN, 16'hA5A5);
    check("t4_led_kept",  ledOut, 16'h00FF);
    bus_read(16'h0000, rd); check("t4_ram0_kept", rd, 16'h0107);

    // 5: reset in RUN, then reset in the middle of a load
    resetN = 1'b1;
    #1;
    check("t5_run_async", {15'd0, run}, 16'h0000);
    tick();
    resetN = 1'b0;
    tick();
    load_word(16'hAAAA, 1'b0);
    load_word(16'hBBBB, 1'b0);
    resetN = 1'b1;
    tick();
    resetN = 1'b0;
    tick();
    load_word(16'hCCCC, 1'b1);
    tick();
    check("t5_run", {15'd0, run}, 16'h0001);
    bus_read(16'h0000, rd); check("t5_ram0", rd, 16'hCCCC);
    bus_read(16'h0001, rd); check("t5_ram1", rd, 16'hBBBB);
    bus_read(16'h0002, rd); check("t5_ram2", rd, 16'h1234);

    // 6: ld_valid toggling, W pulses during LOAD
    do_reset();
    bus.DOUT = 16'hDEAD;
    bus.W    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ld_valid = i[0];
      ld_data  = 16'h6000 + 16'(i);
      ld_last  = (i == 7);
      bus.ADDR = i[0] ? 16'h0002 : 16'h0010;
      tick();
      if (i == 3) check("t6_din_zero", bus.DIN, 16'h0000);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    bus.W    = 1'b0;
    tick();
    check("t6_run", {15'd0, run}, 16'h0001);
    bus_read(16'h0000, rd); check("t6_ram0", rd, 16'h6001);
    bus_read(16'h0001, rd); check("t6_ram1", rd, 16'h6003);
    bus_read(16'h0002, rd); check("t6_ram2", rd, 16'h6005);
    bus_read(16'h0003, rd); check("t6_ram3", rd, 16'h6007);
    bus_read(16'h0010, rd); check("t6_ram16", rd, 16'hBEEF);

    // 2: full-depth load without ld_last stops at the last address
    do_reset();
    for (int i = 0; i < 128; i++) begin
      if (i == 127) check("t2_ready_b4_last", {15'd0, ld_ready}, 16'h0001);
      load_word(16'h8000 + 16'(i), 1'b0);
    end
    ld_valid = 1'b1;
    ld_data  = 16'hFFFF;
    tick();
    tick();
    tick();
    ld_valid = 1'b0;
    check("t2_run",       {15'd0, run}, 16'h0001);
    check("t2_ready_low", {15'd0, ld_ready}, 16'h0000);
    bus_read(16'h0000, rd); check("t2_ram0",   rd, 16'h8000);
    bus_read(16'h0040, rd); check("t2_ram64",  rd, 16'h8040);
    bus_read(16'h007F, rd); check("t2_ram127", rd, 16'h807F);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
